// File: rtl/cprs_4_2_err_recover.sv
// Frame accumulator for a row of 4:2 approximate compressors: sums the approximate
// result and the error-corrected result per frame, counting err bits and beats.
module cprs_4_2_err_recover #(
  parameter int W     = 8,
  parameter int ACC_W = 20,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_summ,
  input  logic [W-1:0]     in_carry,
  input  logic [W-1:0]     in_err,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_exact,
  output logic [ACC_W-1:0] out_apx,
  output logic [CNT_W-1:0] out_err_cnt,
  output logic [CNT_W-1:0] out_beats
);

  localparam int PW = $clog2(W + 1);
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;

  typedef enum logic {ACC, HOLD} state_e;

  state_e             state_q;
  logic [ACC_W-1:0]   exact_q, apx_q;
  logic [CNT_W-1:0]   err_q, beats_q;

  logic [ACC_W-1:0]   beatApx, beatExact;
  logic [ACC_W-1:0]   exact_d, apx_d;
  logic [CNT_W-1:0]   err_d, beats_d;
  logic [PW-1:0]      popCnt;
  logic [SW-1:0]      errSum;
  logic               transfer;

  assign in_ready    = (state_q == ACC) & ~rst;
  assign out_valid   = (state_q == HOLD) & ~rst;
  assign transfer    = in_valid & in_ready;
  assign out_exact   = exact_q;
  assign out_apx     = apx_q;
  assign out_err_cnt = err_q;
  assign out_beats   = beats_q;

  // Each flagged column lost its weight-2 term, so the correction is err shifted by one.
  always_comb begin
    popCnt = '0;
    for (int i = 0; i < W; i++) begin
      popCnt = popCnt + PW'(in_err[i]);
    end
    beatApx   = ACC_W'(in_summ) + (ACC_W'(in_carry) << 1);
    beatExact = beatApx + (ACC_W'(in_err) << 1);
    apx_d     = apx_q + beatApx;
    exact_d   = exact_q + beatExact;
    errSum    = SW'(err_q) + SW'(popCnt);
    err_d     = (errSum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : errSum[CNT_W-1:0];
    beats_d   = (beats_q == {CNT_W{1'b1}}) ? beats_q : beats_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      exact_q <= '0;
      apx_q   <= '0;
      err_q   <= '0;
      beats_q <= '0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (transfer) begin
            exact_q <= exact_d;
            apx_q   <= apx_d;
            err_q   <= err_d;
            beats_q <= beats_d;
            if (in_last) state_q <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= ACC;
            exact_q <= '0;
            apx_q   <= '0;
            err_q   <= '0;
            beats_q <= '0;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_cprs_4_2_err_recover.sv
// Bench for cprs_4_2_err_recover: a default-sized and a narrow instance share stimulus,
// checked each cycle against an arithmetic frame model plus hand-computed frame results.
module tb_cprs_4_2_err_recover;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_last, out_ready;
  logic [7:0]  in_summ, in_carry, in_err;

  logic        in_ready, out_valid;
  logic [19:0] out_exact, out_apx;
  logic [15:0] out_err_cnt, out_beats;

  logic        sInReady, sOutValid;
  logic [11:0] sExact, sApx;
  logic [3:0]  sErrCnt, sBeats;

  int checks = 0;
  int errors = 0;

  // Frame model: unbounded integer sums, wrapped/saturated only when compared
  longint mApx, mExact, mErr, mBeats;
  bit     mHold = 1'b0, mKnown = 1'b0, mLastRst = 1'b0;

  always #5 clk = ~clk;

  cprs_4_2_err_recover #(.W(8), .ACC_W(20), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_summ(in_summ), .in_carry(in_carry), .in_err(in_err), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_exact(out_exact),
    .out_apx(out_apx), .out_err_cnt(out_err_cnt), .out_beats(out_beats)
  );

  cprs_4_2_err_recover #(.W(8), .ACC_W(12), .CNT_W(4)) dutSmall (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sInReady),
    .in_summ(in_summ), .in_carry(in_carry), .in_err(in_err), .in_last(in_last),
    .out_valid(sOutValid), .out_ready(out_ready), .out_exact(sExact),
    .out_apx(sApx), .out_err_cnt(sErrCnt), .out_beats(sBeats)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // Compare, then advance the model by what the coming rising edge will do
  always @(negedge clk) begin
    if (mKnown) begin
      check("in_ready", in_ready, !mHold && !rst);
      check("out_valid", out_valid, mHold && !rst);
      check("small.in_ready", sInReady, !mHold && !rst);
      check("small.out_valid", sOutValid, mHold && !rst);
      if (mHold || mLastRst) begin
        check("exact", out_exact, mExact % 64'd1048576);
        check("apx", out_apx, mApx % 64'd1048576);
        check("err_cnt", out_err_cnt, sat(mErr, 65535));
        check("beats", out_beats, sat(mBeats, 65535));
        check("small.exact", sExact, mExact % 64'd4096);
        check("small.apx", sApx, mApx % 64'd4096);
        check("small.err_cnt", sErrCnt, sat(mErr, 15));
        check("small.beats", sBeats, sat(mBeats, 15));
      end
    end
    mLastRst = rst;
    if (rst) begin
      mKnown = 1'b1;
      mHold  = 1'b0;
      mApx = 0; mExact = 0; mErr = 0; mBeats = 0;
    end else if (mHold) begin
      if (out_ready) begin
        mHold = 1'b0;
        mApx = 0; mExact = 0; mErr = 0; mBeats = 0;
      end
    end else if (in_valid) begin
      mApx   += longint'(in_summ) + 2 * longint'(in_carry);
      mExact += longint'(in_summ) + 2 * longint'(in_carry) + 2 * longint'(in_err);
      mErr   += $countones(in_err);
      mBeats += 1;
      if (in_last) mHold = 1'b1;
    end
  end

  task automatic applyStimulus(input logic [7:0] s, input logic [7:0] c,
                               input logic [7:0] e, input logic l);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_summ  = s;
    in_carry = c;
    in_err   = e;
    in_last  = l;
  endtask

  task automatic applyIdle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  // Waits (bounded) for the result; latency counts negedges after the last beat was driven
  task automatic checkOutput(input string name, input bit chkLat,
                             input longint be, input longint ba, input longint bc, input longint bb,
                             input longint se, input longint sa, input longint sc, input longint sb);
    int n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (out_valid === 1'b1 || n >= 20) break;
    end
    check({name, ".valid"}, out_valid, 1);
    if (chkLat) check({name, ".latency"}, n, 2);
    check({name, ".exact"}, out_exact, be);
    check({name, ".apx"}, out_apx, ba);
    check({name, ".err_cnt"}, out_err_cnt, bc);
    check({name, ".beats"}, out_beats, bb);
    check({name, ".small.exact"}, sExact, se);
    check({name, ".small.apx"}, sApx, sa);
    check({name, ".small.err_cnt"}, sErrCnt, sc);
    check({name, ".small.beats"}, sBeats, sb);
  endtask

  task automatic handoff(input string name);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({name, ".after.in_ready"}, in_ready, 1);
    check({name, ".after.out_valid"}, out_valid, 0);
    check({name, ".after.exact"}, out_exact, 0);
    check({name, ".after.err_cnt"}, out_err_cnt, 0);
    check({name, ".after.beats"}, out_beats, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_summ = '0; in_carry = '0; in_err = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.in_ready", in_ready, 0);
    check("reset.out_valid", out_valid, 0);
    check("reset.exact", out_exact, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset.in_ready", in_ready, 1);

    applyStimulus(8'h0F, 8'h01, 8'h00, 1'b1);
    checkOutput("single", 1'b1, 17, 17, 0, 1, 17, 17, 0, 1);
    handoff("single");

    applyStimulus(8'h00, 8'h00, 8'h81, 1'b1);
    checkOutput("err81", 1'b1, 258, 0, 2, 1, 258, 0, 2, 1);
    handoff("err81");

    applyStimulus(8'hFF, 8'hFF, 8'hFF, 1'b0);
    applyIdle(1);
    applyStimulus(8'hFF, 8'hFF, 8'hFF, 1'b0);
    applyStimulus(8'hFF, 8'hFF, 8'hFF, 1'b1);
    checkOutput("allones", 1'b1, 3825, 2295, 24, 3, 3825, 2295, 15, 3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_summ  = 8'hA5 ^ 8'(i);
      in_carry = 8'h3C;
      in_err   = 8'h0F;
      in_last  = 1'b1;
    end
    checkOutput("stall", 1'b0, 3825, 2295, 24, 3, 3825, 2295, 15, 3);
    handoff("stall");

    applyStimulus(8'h10, 8'h00, 8'h01, 1'b0);
    applyStimulus(8'h20, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("midframe_rst.out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(8'h01, 8'h00, 8'h00, 1'b1);
    checkOutput("after_rst", 1'b1, 1, 1, 0, 1, 1, 1, 0, 1);
    handoff("after_rst");

    applyStimulus(8'h05, 8'h00, 8'h00, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("hold_rst.out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("hold_rst.beats", out_beats, 0);

    for (int i = 0; i < 4; i++) applyStimulus(8'hFF, 8'hFF, 8'hFF, i == 3);
    checkOutput("wrap", 1'b1, 5100, 3060, 32, 4, 1004, 3060, 15, 4);
    handoff("wrap");

    applyStimulus(8'h00, 8'h00, 8'hFF, 1'b0);
    applyStimulus(8'h00, 8'h00, 8'hFF, 1'b0);
    applyStimulus(8'h00, 8'h00, 8'h0F, 1'b1);
    checkOutput("errsat", 1'b1, 1050, 0, 20, 3, 1050, 0, 15, 3);
    handoff("errsat");

    for (int i = 0; i < 18; i++) applyStimulus(8'h01, 8'h00, 8'h00, i == 17);
    checkOutput("beatsat", 1'b1, 18, 18, 0, 18, 18, 18, 0, 15);
    handoff("beatsat");

    applyIdle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
